// File: rtl/memwb_pkg.sv
// MEM/WB shared types: payload bundle and skid buffer state.
// Optional MEMWB_FWD_EN adds an execute-stage bypass port on memwb_pipe.
package memwb_pkg;

  localparam int MEMWB_DATA_W   = 32;
  localparam int MEMWB_REG_W    = 5;
  localparam int MEMWB_THREAD_W = 2;

  typedef struct packed {
    logic [MEMWB_DATA_W-1:0]   alu;
    logic [MEMWB_DATA_W-1:0]   lmd;
    logic [MEMWB_REG_W-1:0]    reg_dst;
    logic                      mem_write;
    logic                      alu_write;
    logic [MEMWB_THREAD_W-1:0] tid;
  } memwb_payload_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

endpackage

// File: rtl/memwb_skid.sv
// Generic 2-entry skid buffer; entries whose low KW bits match
// flush_key are killed after the cycle's retire/accept.
module memwb_skid
  import memwb_pkg::*;
#(
  parameter int W  = 8,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  input  logic          flush,
  input  logic [KW-1:0] flush_key
);

  state_t       state;
  state_t       nstate;
  logic [W-1:0] skid_data;
  logic [W-1:0] nout;
  logic [W-1:0] nskid;

  logic retire;
  logic accept;
  logic kill_out;
  logic kill_skid;
  logic kill_in;
  logic keep_out;
  logic keep_skid;
  logic take_in;

  assign out_valid = (state != EMPTY);
  assign retire    = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  assign kill_out  = flush && (out_data[KW-1:0] == flush_key);
  assign kill_skid = flush && (skid_data[KW-1:0] == flush_key);
  assign kill_in   = flush && (in_data[KW-1:0] == flush_key);

  assign keep_out  = out_valid && !retire && !kill_out;
  assign keep_skid = (state == FULL) && !kill_skid;
  assign take_in   = accept && !kill_in;

  // Survivors fill OUT first, then SKID, in arrival order.
  always_comb begin
    nstate = EMPTY;
    nout   = out_data;
    nskid  = skid_data;
    if (keep_out) begin
      nstate = ONE;
      if (keep_skid) begin
        nstate = FULL;
      end else if (take_in) begin
        nstate = FULL;
        nskid  = in_data;
      end
    end else if (keep_skid) begin
      nstate = ONE;
      nout   = skid_data;
      if (take_in) begin
        nstate = FULL;
        nskid  = in_data;
      end
    end else if (take_in) begin
      nstate = ONE;
      nout   = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      state     <= nstate;
      in_ready  <= (nstate != FULL);
      out_data  <= nout;
      skid_data <= nskid;
    end
  end

endmodule

// File: rtl/memwb_pipe.sv
// MEM/WB stage: handshake + skid buffer with per-thread flush.
// Define MEMWB_FWD_EN for the fwd_* bypass outputs.
module memwb_pipe
  import memwb_pkg::*;
#(
  parameter int DATA_W   = MEMWB_DATA_W,
  parameter int REG_W    = MEMWB_REG_W,
  parameter int THREAD_W = MEMWB_THREAD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_W-1:0]   alu_i,
  input  logic [DATA_W-1:0]   lmd_i,
  input  logic [REG_W-1:0]    reg_dst_i,
  input  logic                mem_write_i,
  input  logic                alu_write_i,
  input  logic [THREAD_W-1:0] tid_i,
  input  logic                flush_i,
  input  logic [THREAD_W-1:0] flush_tid_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   alu_o,
  output logic [DATA_W-1:0]   lmd_o,
  output logic [REG_W-1:0]    reg_dst_o,
  output logic                mem_write_o,
  output logic                alu_write_o,
  output logic [THREAD_W-1:0] tid_o
`ifdef MEMWB_FWD_EN
  ,
  output logic                fwd_valid_o,
  output logic [REG_W-1:0]    fwd_reg_o,
  output logic [DATA_W-1:0]   fwd_data_o
`endif
);

  localparam int PW = 2 * DATA_W + REG_W + 2 + THREAD_W;

  logic [PW-1:0] in_data;
  logic [PW-1:0] out_data;

  // tid sits in the low bits so the skid buffer can key flushes on it.
  assign in_data = {alu_i, lmd_i, reg_dst_i,
                    mem_write_i, alu_write_i, tid_i};

  assign {alu_o, lmd_o, reg_dst_o,
          mem_write_o, alu_write_o, tid_o} = out_data;

  memwb_skid #(
    .W  (PW),
    .KW (THREAD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (in_data),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (out_data),
    .flush     (flush_i),
    .flush_key (flush_tid_i)
  );

`ifdef MEMWB_FWD_EN
  assign fwd_valid_o = out_valid_o && (mem_write_o || alu_write_o);
  assign fwd_reg_o   = reg_dst_o;
  assign fwd_data_o  = mem_write_o ? lmd_o : alu_o;
`endif

endmodule
